encoder_8to3: RTL and testbench
===============================

ENCODER_8TO3 -- requirements
Module: encoder_8to3

Interface
REQ-001 Parameters: none; widths fixed at 8 request lines and a 3-bit code.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  request-capture enable; when 0, Y7..Y0 are ignored.
REQ-005 Y7,Y6,Y5,Y4,Y3,Y2,Y1,Y0  input  1 each  request lines; Yn is index n.
REQ-006 A,B,C  output  1 each  registered granted code; A is the MSB, so {A,B,C}=3'b010 means index 2.
REQ-007 out_valid  output  1  {A,B,C} holds a granted index.
REQ-008 out_ready  input  1  consumer accepts the code in this cycle.
REQ-009 pending  output  8  registered pending-request vector; bit n is index n.

Function
REQ-010 Define new = en ? {Y7..Y0} : 8'h00, sampled at each posedge.
REQ-011 Define the handshake as out_valid && out_ready in the same cycle.
REQ-012 FSM has two states. IDLE: out_valid=0. HOLD: out_valid=1.
REQ-013 IDLE, with (pending|new)!=0: pending<=pending|new; code<=select(pending|new); go to HOLD. Latency from request to out_valid is 1 cycle.
REQ-014 IDLE, with (pending|new)==0: stay in IDLE; outputs unchanged.
REQ-015 HOLD, no handshake: pending<=pending|new; {A,B,C} stays stable, including when a higher-priority request arrives.
REQ-016 HOLD, with handshake: let m=(pending & ~onehot(code))|new.
- pending<=m.
- If m!=0: code<=select(m); stay in HOLD. Back-to-back grants, no bubble.
- Else go to IDLE with out_valid=0.
REQ-017 If a new request hits the bit being granted in the same cycle, the set wins: that bit stays pending and is granted again later.
REQ-018 select() is fixed priority by default: the highest set index wins (Y7 highest, Y0 lowest).
REQ-019 A request pulse of one cycle with en=1 is latched; a held request line is not counted twice. Pending is a set, not a counter.
REQ-020 If en drops while requests are pending, already-pending bits are still granted in order.

Reset
REQ-021 On rst=1 at a posedge, the state becomes: pending=8'h00, {A,B,C}=3'b000, out_valid=0, FSM=IDLE, round-robin pointer=3'd0.
REQ-022 rst overrides all other inputs. Mid-operation reset discards pending requests and any un-handshaken grant.
REQ-023 The first posedge after reset deasserts obeys REQ-013.

Configuration
REQ-024 Macro ENCODER_ROUND_ROBIN_EN selects the round-robin option.
REQ-025 When defined, select() searches downward from (last_grant-1) mod 8 with wrap-around.
REQ-026 last_grant updates on each handshake to the granted index and resets to 0, so the first search starts at index 7.
REQ-027 When undefined, select() is fixed priority per REQ-018, and no pointer register exists.

Structure
REQ-028 Shared package encoder_pkg holds:
- REQ_W=8 and CODE_W=3;
- the FSM state encodings ST_IDLE=1'b0 and ST_HOLD=1'b1;
- the onehot(code) function.
REQ-029 A combinational sub-module priority_select_8 holds the selection logic.
- Inputs: req[7:0] and start[2:0].
- Outputs: idx[2:0] and any.
- Fixed mode ties start to 3'd7.
REQ-030 encoder_8to3 contains only the FSM, the pending register, the output registers and the optional pointer.

Verification
REQ-031 Reset: apply rst, then Y=8'h00 for 5 cycles -> out_valid=0, {A,B,C}=000, pending=00.
REQ-032 Single request: en=1 with a 1-cycle pulse on Y2, out_ready=1 -> the next cycle shows out_valid=1 and ABC=010; the cycle after shows out_valid=0 and pending=00.
REQ-033 Multiple requests, out_ready=1: en=1, pulse Y7,Y4,Y1 together -> codes 111, 100, 001 on 3 consecutive cycles, then IDLE.
REQ-034 Backpressure: out_ready=0, pulse Y3, then Y6 while holding -> ABC stays 011 until out_ready=1, then 110 follows with no bubble.
REQ-035 Set-wins: in HOLD on code 101 with out_ready=1, pulse Y5 again -> pending bit 5 stays 1 and 101 is granted a second time. Also: en=0 with Y=8'hFF -> no capture.
REQ-036 ENCODER_ROUND_ROBIN_EN defined: Y7 and Y6 held high with out_ready=1 -> codes alternate 111, 110, 111, 110. With the macro undefined, the code stays 111 every cycle. A reset mid-stream -> the next grant is 111 again.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the 8-to-3 request encoder.
// Widths, FSM state encodings and the code-to-one-hot helper.
package encoder_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Expand a granted index into its request-line mask.
  function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [REQ_W-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/encoder_8to3_select.sv
// priority_select_8: combinational request selector.
// Scans downward from 'start' with wrap-around and returns the first set
// index. start=7 gives plain fixed priority (highest index wins).
module priority_select_8
  import encoder_pkg::*;
(
  input  logic [REQ_W-1:0]  req,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Downward circular search; the first hit is kept, later hits are ignored.
  always_comb begin
    logic [CODE_W-1:0] cand;
    idx  = '0;
    any  = 1'b0;
    cand = start;
    for (int i = 0; i < REQ_W; i++) begin
      cand = start - CODE_W'(i);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_8to3.sv
// encoder_8to3: registered 8-to-3 request encoder with a valid/ready output.
// Requests are collected into a pending set; one index is granted at a time
// and held stable until the consumer takes it.
// Build option: define ENCODER_ROUND_ROBIN_EN for round-robin selection
// (default is fixed priority, Y7 highest).
module encoder_8to3
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             Y7,
  input  logic             Y6,
  input  logic             Y5,
  input  logic             Y4,
  input  logic             Y3,
  input  logic             Y2,
  input  logic             Y1,
  input  logic             Y0,
  input  logic             out_ready,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             out_valid,
  output logic [REQ_W-1:0] pending
);

  state_t              state;
  logic [CODE_W-1:0]   code;
  logic [REQ_W-1:0]    new_req;
  logic [REQ_W-1:0]    merged;
  logic [REQ_W-1:0]    sel_req;
  logic                handshake;
  logic [CODE_W-1:0]   start;
  logic [CODE_W-1:0]   sel_idx;
  logic                sel_any;

  assign new_req   = en ? {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} : '0;
  assign handshake = (state == ST_HOLD) && out_ready;
  // Retire the granted bit, but a same-cycle re-request of it sets it again.
  assign merged    = (pending & ~onehot(code)) | new_req;
  assign sel_req   = (state == ST_HOLD) ? merged : (pending | new_req);

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_grant;

  // On a handshake the next search already starts below the index being
  // retired, so back-to-back grants rotate without a dead cycle.
  assign start = handshake ? (code - 3'd1) : (last_grant - 3'd1);

  // Remember the most recently accepted index.
  always_ff @(posedge clk) begin
    if (rst)            last_grant <= '0;
    else if (handshake) last_grant <= code;
  end
`else
  assign start = CODE_W'(REQ_W - 1);
`endif

  priority_select_8 u_select (
    .req   (sel_req),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Grant FSM: collects requests, holds a grant until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      code    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_any) begin
            pending <= sel_req;
            code    <= sel_idx;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            pending <= merged;
            if (sel_any) code  <= sel_idx;
            else         state <= ST_IDLE;
          end else begin
            pending <= pending | new_req;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign {A, B, C} = code;
  assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_encoder_8to3.sv
// Testbench for encoder_8to3: table of per-cycle vectors with hand-derived
// expected outputs, plus a rotation/reset sequence whose expectations depend
// on the ENCODER_ROUND_ROBIN_EN build option.
module tb_encoder_8to3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] y;
  logic       out_ready;
  logic       A, B, C;
  logic       out_valid;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

`ifdef ENCODER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] y;
    logic       rdy;
    logic       v;
    logic [2:0] c;
    logic [7:0] p;
    string      name;
  } vec_t;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic [7:0] p;
    string      name;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .Y7        (y[7]),
    .Y6        (y[6]),
    .Y5        (y[5]),
    .Y4        (y[4]),
    .Y3        (y[3]),
    .Y2        (y[2]),
    .Y1        (y[1]),
    .Y0        (y[0]),
    .out_ready (out_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [7:0] yy,
                     input logic rd, input logic v, input logic [2:0] c,
                     input logic [7:0] p, input string name);
    vec_t t;
    t.rst = r; t.en = e; t.y = yy; t.rdy = rd;
    t.v = v; t.c = c; t.p = p; t.name = name;
    vt.push_back(t);
  endtask

  // Drive one cycle of inputs, queue its expectation, check after the edge.
  task automatic step(input logic r, input logic e, input logic [7:0] yy,
                      input logic rd, input logic v, input logic [2:0] c,
                      input logic [7:0] p, input string name);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst = r; en = e; y = yy; out_ready = rd;
    x.v = v; x.c = c; x.p = p; x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    if ({out_valid, A, B, C, pending} !== {got.v, got.c, got.p}) begin
      errors++;
      $display("FAIL %s: got valid=%0b abc=%03b pending=%02h, expected valid=%0b abc=%03b pending=%02h",
               got.name, out_valid, {A, B, C}, pending, got.v, got.c, got.p);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; y = 8'h00; out_ready = 1'b0;

    // reset, overriding active requests
    add(1, 1, 8'hFF, 1, 0, 3'd0, 8'h00, "reset_override");
    for (int i = 0; i < 4; i++)
      add(0, 1, 8'h00, 0, 0, 3'd0, 8'h00, "reset_idle");
    // single request on Y2
    add(0, 1, 8'h04, 1, 1, 3'd2, 8'h04, "single_grant");
    add(0, 1, 8'h00, 1, 0, 3'd2, 8'h00, "single_retire");
    // Y7,Y4,Y1 together
    add(0, 1, 8'h92, 1, 1, 3'd7, 8'h92, "multi_7");
    add(0, 1, 8'h00, 1, 1, 3'd4, 8'h12, "multi_4");
    add(0, 1, 8'h00, 1, 1, 3'd1, 8'h02, "multi_1");
    add(0, 1, 8'h00, 1, 0, 3'd1, 8'h00, "multi_idle");
    // backpressure, higher request arrives while holding
    add(0, 1, 8'h08, 0, 1, 3'd3, 8'h08, "bp_grant3");
    add(0, 1, 8'h40, 0, 1, 3'd3, 8'h48, "bp_hold_y6");
    add(0, 1, 8'h00, 0, 1, 3'd3, 8'h48, "bp_hold");
    add(0, 1, 8'h00, 1, 1, 3'd6, 8'h40, "bp_next6");
    add(0, 1, 8'h00, 1, 0, 3'd6, 8'h00, "bp_idle");
    // set wins on the bit being retired
    add(0, 1, 8'h20, 1, 1, 3'd5, 8'h20, "setwins_grant");
    add(0, 1, 8'h20, 1, 1, 3'd5, 8'h20, "setwins_regrant");
    add(0, 1, 8'h00, 1, 0, 3'd5, 8'h00, "setwins_idle");
    // capture disabled
    add(0, 0, 8'hFF, 1, 0, 3'd5, 8'h00, "en0_ignore_a");
    add(0, 0, 8'hFF, 0, 0, 3'd5, 8'h00, "en0_ignore_b");
    // en drops with bits pending
    add(0, 1, 8'hA0, 0, 1, 3'd7, 8'hA0, "endrop_grant7");
    add(0, 0, 8'hFF, 1, 1, 3'd5, 8'h20, "endrop_grant5");
    add(0, 0, 8'hFF, 1, 0, 3'd5, 8'h00, "endrop_idle");
    // held line is one pending entry, granted repeatedly
    add(0, 1, 8'h80, 1, 1, 3'd7, 8'h80, "held7_a");
    add(0, 1, 8'h80, 1, 1, 3'd7, 8'h80, "held7_b");
    add(0, 1, 8'h00, 1, 0, 3'd7, 8'h00, "held7_idle");
    // reset in the middle of a held grant
    add(0, 1, 8'h0F, 0, 1, 3'd3, 8'h0F, "midrst_setup");
    add(1, 1, 8'hFF, 1, 0, 3'd0, 8'h00, "midrst_clear");
    add(0, 1, 8'h00, 1, 0, 3'd0, 8'h00, "midrst_idle");
    add(0, 1, 8'h01, 1, 1, 3'd0, 8'h01, "grant_index0");
    add(0, 1, 8'h00, 1, 0, 3'd0, 8'h00, "index0_idle");

    for (int i = 0; i < vt.size(); i++)
      step(vt[i].rst, vt[i].en, vt[i].y, vt[i].rdy,
           vt[i].v, vt[i].c, vt[i].p, vt[i].name);

    // Y7 and Y6 held high: rotation or fixed priority depending on build
    step(1, 1, 8'hC0, 1, 0, 3'd0, 8'h00, "rot_reset");
    step(0, 1, 8'hC0, 1, 1, 3'd7, 8'hC0, "rot_1");
    step(0, 1, 8'hC0, 1, 1, RR ? 3'd6 : 3'd7, 8'hC0, "rot_2");
    step(0, 1, 8'hC0, 1, 1, 3'd7, 8'hC0, "rot_3");
    step(0, 1, 8'hC0, 1, 1, RR ? 3'd6 : 3'd7, 8'hC0, "rot_4");
    // reset mid-stream restarts the search at index 7
    step(1, 1, 8'hC0, 1, 0, 3'd0, 8'h00, "rot_midreset");
    step(0, 1, 8'hC0, 1, 1, 3'd7, 8'hC0, "rot_after_rst");
    step(0, 1, 8'hC0, 1, 1, RR ? 3'd6 : 3'd7, 8'hC0, "rot_after_rst2");
    step(0, 1, 8'h00, 1, 1, RR ? 3'd7 : 3'd6, RR ? 8'h80 : 8'h40, "rot_drain");
    step(0, 1, 8'h00, 1, 0, RR ? 3'd7 : 3'd6, 8'h00, "rot_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
